// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative bit-serial shifts and shift-add multiply.
// Result and flags are registered and change only when an operation completes.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic [3:0]         op_code,
    input  logic               zero_store,
    input  logic [WIDTH-1:0]   input_0,
    input  logic [WIDTH-1:0]   input_1,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero_flag,
    output logic               parity_flag,
    output logic               not_equal,
    output logic               carry_flag
);

    localparam int CNT_W = (SHAMT_W > 6) ? SHAMT_W : 6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               ne_pend_q, ne_pend_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               par_q, par_d;
    logic               ne_q, ne_d;
    logic               carry_q, carry_d;

    logic               upd;
    logic [WIDTH-1:0]   new_res;
    logic               new_cy;
    logic               new_ne;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   sh_step;
    logic               sh_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            ne_pend_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            par_q     <= 1'b0;
            ne_q      <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            ne_pend_q <= ne_pend_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            par_q     <= par_d;
            ne_q      <= ne_d;
            carry_q   <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        ne_pend_d = ne_pend_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        result_d  = result_q;
        zero_d    = zero_q;
        par_d     = par_q;
        ne_d      = ne_q;
        carry_d   = carry_q;
        upd       = 1'b0;
        new_res   = '0;
        new_cy    = 1'b0;
        new_ne    = ne_pend_q;

        sum      = {1'b0, input_0} + {1'b0, input_1};
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (op_q == 4'd5) begin
            sh_step = sh_q << 1;
            sh_out  = sh_q[WIDTH-1];
        end else begin
            sh_step = sh_q >> 1;
            sh_out  = sh_q[0];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    new_ne    = (input_0 != input_1);
                    ne_pend_d = new_ne;
                    if (halt) begin
                        upd     = 1'b1;
                        state_d = DONE;
                    end else begin
                        case (op_code)
                            4'd5, 4'd6: begin
                                if (shamt == '0) begin
                                    upd     = 1'b1;
                                    new_res = input_1;
                                    state_d = DONE;
                                end else begin
                                    op_d    = op_code;
                                    cnt_d   = CNT_W'(shamt);
                                    sh_d    = input_1;
                                    state_d = RUN;
                                end
                            end
                            4'd8: begin
                                op_d     = op_code;
                                cnt_d    = CNT_W'(WIDTH);
                                mcand_d  = {{WIDTH{1'b0}}, input_0};
                                mplier_d = input_1;
                                acc_d    = '0;
                                state_d  = RUN;
                            end
                            default: begin
                                upd     = 1'b1;
                                state_d = DONE;
                                case (op_code)
                                    4'd0: new_res = input_0 & input_1;
                                    4'd1: new_res = input_0 | input_1;
                                    4'd2: begin
                                        new_res = sum[WIDTH-1:0];
                                        new_cy  = sum[WIDTH];
                                    end
                                    4'd3: begin
                                        new_res = input_0 - input_1;
                                        new_cy  = (input_0 < input_1);
                                    end
                                    4'd4: new_res = input_0 ^ input_1;
                                    4'd7: new_res = zero_store ? input_1 : input_0;
                                    default: new_res = '0;
                                endcase
                            end
                        endcase
                    end
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q == 4'd8) begin
                        acc_d    = acc_step;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        new_res  = acc_step[WIDTH-1:0];
                        new_cy   = |acc_step[2*WIDTH-1:WIDTH];
                    end else begin
                        sh_d    = sh_step;
                        new_res = sh_step;
                        new_cy  = sh_out;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        upd     = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (upd) begin
            result_d = new_res;
            zero_d   = (new_res == '0);
            par_d    = ^new_res;
            carry_d  = new_cy;
            ne_d     = new_ne;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        result      = result_q;
        zero_flag   = zero_q;
        parity_flag = par_q;
        not_equal   = ne_q;
        carry_flag  = carry_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8, SHAMT_W=3) with hand-computed expectations.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic [3:0] op_code;
    logic       zero_store;
    logic [7:0] input_0;
    logic [7:0] input_1;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero_flag;
    logic       parity_flag;
    logic       not_equal;
    logic       carry_flag;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .op_code(op_code), .zero_store(zero_store),
        .input_0(input_0), .input_1(input_1), .shamt(shamt),
        .busy(busy), .done(done), .result(result),
        .zero_flag(zero_flag), .parity_flag(parity_flag),
        .not_equal(not_equal), .carry_flag(carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] res, input logic z,
                           input logic p, input logic ne, input logic cy);
        chk({tag, ".result"}, {24'd0, result}, {24'd0, res});
        chk({tag, ".zero"}, {31'd0, zero_flag}, {31'd0, z});
        chk({tag, ".parity"}, {31'd0, parity_flag}, {31'd0, p});
        chk({tag, ".ne"}, {31'd0, not_equal}, {31'd0, ne});
        chk({tag, ".carry"}, {31'd0, carry_flag}, {31'd0, cy});
    endtask

    task automatic chk_ctl(input string tag, input logic b, input logic d);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic single_op(input string tag, input logic [3:0] op, input logic zs,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                             input logic z, input logic p, input logic ne, input logic cy);
        op_code = op; zero_store = zs; input_0 = a; input_1 = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl({tag, ".k1"}, 1'b1, 1'b1);
        chk_out(tag, res, z, p, ne, cy);
        tick();
        chk_ctl({tag, ".k2"}, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; op_code = 4'd0;
        zero_store = 1'b0; input_0 = 8'h00; input_1 = 8'h00; shamt = 3'd0;
        #2;
        chk_ctl("reset", 1'b0, 1'b0);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // ADD wrap with carry
        single_op("add_ff_01", 4'd2, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

        // MUL 0x0F*0x11: busy k..k+9, done at k+9
        op_code = 4'd8; input_0 = 8'h0F; input_1 = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            chk_ctl("mul1_run", 1'b1, 1'b0);
            chk("mul1_hidden", {24'd0, result}, 32'h00);
            tick();
        end
        chk_ctl("mul1_done", 1'b1, 1'b1);
        chk_out("mul1", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_ctl("mul1_idle", 1'b0, 1'b0);

        // MUL 0x10*0x10 overflows to zero with carry
        op_code = 4'd8; input_0 = 8'h10; input_1 = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk_ctl("mul2_done", 1'b1, 1'b1);
        chk_out("mul2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // SHL 0x81 by 3: done at k+4
        op_code = 4'd5; input_0 = 8'h81; input_1 = 8'h81; shamt = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("shl_k1", 1'b1, 1'b0);
        tick();
        chk_ctl("shl_k2", 1'b1, 1'b0);
        tick();
        chk_ctl("shl_k3", 1'b1, 1'b0);
        tick();
        chk_ctl("shl_k4", 1'b1, 1'b1);
        chk_out("shl", 8'h08, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // SHR 0x81 by 1: done at k+2
        op_code = 4'd6; input_0 = 8'h00; input_1 = 8'h81; shamt = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("shr_k1", 1'b1, 1'b0);
        tick();
        chk_ctl("shr_k2", 1'b1, 1'b1);
        chk_out("shr", 8'h40, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // Shift by zero behaves single-cycle
        shamt = 3'd0;
        single_op("shl_z", 4'd5, 1'b0, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);

        single_op("and", 4'd0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
        single_op("or", 4'd1, 1'b0, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        single_op("xor", 4'd4, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        single_op("pass0", 4'd7, 1'b0, 8'h12, 8'h34, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        single_op("pass1", 4'd7, 1'b1, 8'h12, 8'h34, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0);
        single_op("add_80", 4'd2, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        single_op("sub_eq", 4'd3, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        single_op("sub_pos", 4'd3, 1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
        single_op("rsvd", 4'd15, 1'b0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // start held with new operands during MUL is ignored
        op_code = 4'd8; input_0 = 8'h03; input_1 = 8'h05; start = 1'b1;
        tick();
        op_code = 4'd2; input_0 = 8'h07; input_1 = 8'h09;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk_ctl("mulhold_done", 1'b1, 1'b1);
        chk_out("mulhold", 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk("mulhold_early_done", done_cnt, 0);
        chk_ctl("mulhold_idle", 1'b0, 1'b0);

        // SUB with borrow: 0x03-0x05 = 0xFE
        single_op("sub_neg", 4'd3, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b1);

        // halt at k+3 of a MUL aborts silently
        op_code = 4'd8; input_0 = 8'h02; input_1 = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk_ctl("mul_abort", 1'b0, 1'b0);
        chk_out("mul_abort", 8'hFE, 1'b0, 1'b1, 1'b1, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("mul_abort_nodone", done_cnt, 0);

        // halt with start in IDLE: single-cycle no-op
        halt = 1'b1;
        single_op("halt_nop", 4'd2, 1'b0, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        halt = 1'b0;

        // halt in DONE has no effect
        op_code = 4'd2; input_0 = 8'h01; input_1 = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        halt = 1'b1;
        chk_ctl("halt_done_k1", 1'b1, 1'b1);
        tick();
        halt = 1'b0;
        chk_ctl("halt_done_k2", 1'b0, 1'b0);
        chk_out("halt_done", 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);

        // start held across DONE: ignored in DONE, accepted the cycle after
        op_code = 4'd2; input_0 = 8'h10; input_1 = 8'h20; start = 1'b1;
        tick();
        op_code = 4'd0; input_0 = 8'h0C; input_1 = 8'h0A;
        chk("b2b_first", {24'd0, result}, 32'h30);
        tick();
        chk_ctl("b2b_gap", 1'b0, 1'b0);
        chk("b2b_gap_res", {24'd0, result}, 32'h30);
        tick();
        start = 1'b0;
        chk_ctl("b2b_second", 1'b1, 1'b1);
        chk("b2b_second_res", {24'd0, result}, 32'h08);
        tick();

        // reset mid-SHL, then ADD accepted on first edge after release
        op_code = 4'd5; input_0 = 8'h00; input_1 = 8'h01; shamt = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("rst_mid", 1'b0, 1'b0);
        chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("rst_nodone", done_cnt, 0);
        op_code = 4'd2; input_0 = 8'h02; input_1 = 8'h03; start = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("rst_resume", 1'b1, 1'b1);
        chk_out("rst_resume", 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_ctl("rst_resume_idle", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal: 4 to 32).
REQ-002 Parameter SHAMT_W, default 3, shift-amount width; the block SHALL require 2**SHAMT_W >= WIDTH.
REQ-003 clk  in  1  rising-edge clock; all state changes on this edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 halt  in  1  no-op/abort control.
REQ-007 op_code  in  4  operation select.
REQ-008 zero_store  in  1  PASS select: 0 gives input_0, 1 gives input_1.
REQ-009 input_0, input_1  in  WIDTH  operands.
REQ-010 shamt  in  SHAMT_W  shift amount for SHL/SHR.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 result  out  WIDTH  registered result; holds between completions.
REQ-014 zero_flag, parity_flag, not_equal, carry_flag  out  1 each  registered flags.

Function
REQ-015 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 Transitions:
- IDLE to DONE on accepting a single-cycle op.
- IDLE to RUN on accepting an iterative op.
- RUN to DONE when the iteration count expires.
- DONE to IDLE unconditionally.
REQ-017 Acceptance: start=1 in IDLE at a clk edge SHALL latch op_code, zero_store, input_0, input_1 and shamt; start in RUN/DONE SHALL be ignored, not queued.
REQ-018 Operations:
- 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR: single-cycle.
- 5 SHL input_1 by shamt: iterative.
- 6 SHR logical input_1 by shamt: iterative.
- 7 PASS: single-cycle.
- 8 MUL, low WIDTH bits: iterative.
- 9 to 15 reserved: single-cycle, result 0.
REQ-019 Single-cycle ops SHALL update result/flags on the accept edge; done high the following cycle (latency 1).
REQ-020 SHL/SHR SHALL shift one bit per RUN cycle for shamt cycles; done at accept+shamt+1; shamt=0 SHALL behave as single-cycle with result input_1 and carry 0.
REQ-021 MUL SHALL use shift-add, exactly WIDTH RUN cycles; done at accept+WIDTH+1.
REQ-022 carry_flag:
- ADD: carry out of bit WIDTH-1.
- SUB: borrow, set when input_0 < input_1 unsigned.
- SHL/SHR: last bit shifted out.
- MUL: 1 if product bits [2*WIDTH-1:WIDTH] are nonzero.
- All other ops: 0.
REQ-023 zero_flag SHALL be (result==0) and parity_flag SHALL be XOR-reduce(result), both on the final result and updated with result.
REQ-024 not_equal SHALL be (latched input_0 != latched input_1), updated with result.
REQ-025 ADD/SUB/MUL SHALL wrap modulo 2**WIDTH.
REQ-026 result and flags SHALL change only at completion; intermediate RUN values SHALL NOT be visible on result.
REQ-027 halt=1 at acceptance SHALL complete as a single-cycle no-op: result 0, zero_flag 1, parity_flag 0, carry_flag 0, not_equal from operands, done pulsed.
REQ-028 halt=1 during RUN SHALL abort to IDLE on that edge: no done pulse, and result/flags keep their prior values.
REQ-029 halt=1 in DONE SHALL have no effect; the done pulse still completes.
REQ-030 done SHALL never be high for two consecutive cycles; start may be accepted the cycle after DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, iteration counter 0, busy 0, done 0, result 0 and all four flags 0, regardless of clk.
REQ-032 Reset mid-RUN SHALL discard the operation; no done pulse after rst_n deasserts.
REQ-033 Operation SHALL resume at the first clk edge with rst_n=1; start sampled on that edge SHALL be accepted.

Verification (WIDTH=8, accept edge = k)
REQ-034 ADD input_0=0xFF, input_1=0x01 -> done at k+1, result 0x00, zero 1, carry 1, parity 0, not_equal 1.
REQ-035 MUL 0x0F*0x11 -> busy k..k+9, done at k+9, result 0xFF, carry 0, parity 0; MUL 0x10*0x10 -> result 0x00, zero 1, carry 1.
REQ-036 SHL input_1=0x81, shamt=3 -> done at k+4, result 0x08, carry 0; SHR input_1=0x81, shamt=1 -> done at k+2, result 0x40, carry 1.
REQ-037 start held high with new operands during a MUL run -> ignored; one done; result equals first MUL's product.
REQ-038 halt pulsed at k+3 of a MUL run -> IDLE at k+3, no done, result equals previous value; halt with start in IDLE -> done at k+1, result 0x00, zero 1.
REQ-039 rst_n low mid-SHL (shamt=7) -> outputs 0 at once; no done after release; next ADD 0x02+0x03 -> 0x05, parity 0.
